// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data memory port arbiter.
package mem_arb_pkg;

  typedef enum logic {
    REQ_INSTR = 1'b0,
    REQ_DATA  = 1'b1
  } req_id_e;

  typedef enum logic {
    ARB  = 1'b0,
    HOLD = 1'b1
  } arb_state_e;

  localparam logic [3:0] INSTR_BE = 4'hF;

endpackage

// File: rtl/mem_arb_id_fifo.sv
// In-order FIFO of 1-bit requester IDs for outstanding memory transactions.
module mem_arb_id_fifo #(
  parameter int unsigned DEPTH = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             push,
  input  logic                             pop,
  input  logic                             din,
  output logic                             head,
  output logic                             full,
  output logic                             empty,
  output logic [$clog2(DEPTH+1)-1:0]       count
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic          mem_q [DEPTH];
  logic [PW-1:0] rd_q;
  logic [PW-1:0] wr_q;
  logic [CW-1:0] cnt_q;
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] ptr);
    return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);
  endfunction

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign head    = mem_q[rd_q];
  // A full FIFO still takes a push when the same cycle pops.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= ptr_next(wr_q);
      if (do_pop)  rd_q <= ptr_next(rd_q);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates instruction-fetch and data requests onto one memory port and
// routes in-order responses back to the issuing channel.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned MAX_OUT   = 2,
  parameter int unsigned PRIO_MODE = 0,
  parameter int unsigned AW        = 32,
  parameter int unsigned DW        = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          instr_req_i,
  input  logic [AW-1:0] instr_addr_i,
  output logic          instr_gnt_o,
  output logic          instr_rvalid_o,
  output logic [DW-1:0] instr_rdata_o,
  output logic          instr_err_o,
  input  logic          data_req_i,
  input  logic [AW-1:0] data_addr_i,
  input  logic          data_we_i,
  input  logic [3:0]    data_be_i,
  input  logic [DW-1:0] data_wdata_i,
  output logic          data_gnt_o,
  output logic          data_rvalid_o,
  output logic [DW-1:0] data_rdata_o,
  output logic          data_err_o,
  output logic          mem_req_o,
  output logic [AW-1:0] mem_addr_o,
  output logic          mem_we_o,
  output logic [3:0]    mem_be_o,
  output logic [DW-1:0] mem_wdata_o,
  input  logic          mem_gnt_i,
  input  logic          mem_rvalid_i,
  input  logic [DW-1:0] mem_rdata_i,
  input  logic          mem_err_i,
  output logic          busy_o,
  output logic          protocol_err_o
);

  localparam int unsigned CW = $clog2(MAX_OUT + 1);

  arb_state_e    state_q;
  arb_state_e    state_d;
  req_id_e       sel;
  req_id_e       sel_q;
  req_id_e       last_q;
  logic          grant;
  logic          resp_valid;
  logic          can_issue;
  logic          fifo_head;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;

  // Responses are ignored while reset is held; an empty FIFO means a stray rvalid.
  assign resp_valid = mem_rvalid_i && !fifo_empty && !rst;
  // A pop in the same cycle frees a slot for a new grant.
  assign can_issue  = !fifo_full || resp_valid;
  assign grant      = mem_req_o && mem_gnt_i;
  assign busy_o     = mem_req_o || (fifo_count != '0);

  always_comb begin
    state_d   = state_q;
    sel       = REQ_INSTR;
    mem_req_o = 1'b0;
    case (state_q)
      ARB: begin
        if (instr_req_i && data_req_i) begin
          if (PRIO_MODE == 1) sel = REQ_DATA;
          else                sel = (last_q == REQ_INSTR) ? REQ_DATA : REQ_INSTR;
        end else if (data_req_i) begin
          sel = REQ_DATA;
        end
        if ((instr_req_i || data_req_i) && can_issue && !rst) begin
          mem_req_o = 1'b1;
          if (!mem_gnt_i) state_d = HOLD;
        end
      end
      HOLD: begin
        sel       = sel_q;
        mem_req_o = !rst;
        if (mem_gnt_i) state_d = ARB;
      end
      default: state_d = ARB;
    endcase

    if (sel == REQ_DATA) begin
      mem_addr_o  = data_addr_i;
      mem_we_o    = data_we_i;
      mem_be_o    = data_be_i;
      mem_wdata_o = data_wdata_i;
    end else begin
      mem_addr_o  = instr_addr_i;
      mem_we_o    = 1'b0;
      mem_be_o    = INSTR_BE;
      mem_wdata_o = '0;
    end

    instr_gnt_o    = grant && (sel == REQ_INSTR);
    data_gnt_o     = grant && (sel == REQ_DATA);
    instr_rvalid_o = resp_valid && (fifo_head == REQ_INSTR);
    data_rvalid_o  = resp_valid && (fifo_head == REQ_DATA);
    instr_rdata_o  = instr_rvalid_o ? mem_rdata_i : '0;
    data_rdata_o   = data_rvalid_o  ? mem_rdata_i : '0;
    instr_err_o    = instr_rvalid_o && mem_err_i;
    data_err_o     = data_rvalid_o  && mem_err_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ARB;
      sel_q          <= REQ_INSTR;
      last_q         <= REQ_INSTR;
      protocol_err_o <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ARB && state_d == HOLD) sel_q <= sel;
      if (grant) last_q <= sel;
      if (mem_rvalid_i && fifo_empty) protocol_err_o <= 1'b1;
    end
  end

  mem_arb_id_fifo #(
    .DEPTH (MAX_OUT)
  ) u_id_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (grant),
    .pop   (resp_valid),
    .din   (sel),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized checks of mem_port_arbiter against a queue-based model.
module tb_mem_port_arbiter;

  localparam int unsigned MAX_OUT = 2;
  localparam int unsigned PRIO    = 0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        instr_req_i = 1'b0;
  logic [31:0] instr_addr_i = '0;
  logic        instr_gnt_o, instr_rvalid_o, instr_err_o;
  logic [31:0] instr_rdata_o;
  logic        data_req_i = 1'b0;
  logic [31:0] data_addr_i = '0;
  logic        data_we_i = 1'b0;
  logic [3:0]  data_be_i = '0;
  logic [31:0] data_wdata_i = '0;
  logic        data_gnt_o, data_rvalid_o, data_err_o;
  logic [31:0] data_rdata_o;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [3:0]  mem_be_o;
  logic        mem_gnt_i = 1'b0;
  logic        mem_rvalid_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;
  logic        mem_err_i = 1'b0;
  logic        busy_o, protocol_err_o;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .MAX_OUT(MAX_OUT), .PRIO_MODE(PRIO), .AW(32), .DW(32)
  ) dut (
    .clk(clk), .rst(rst),
    .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i), .instr_gnt_o(instr_gnt_o),
    .instr_rvalid_o(instr_rvalid_o), .instr_rdata_o(instr_rdata_o), .instr_err_o(instr_err_o),
    .data_req_i(data_req_i), .data_addr_i(data_addr_i), .data_we_i(data_we_i),
    .data_be_i(data_be_i), .data_wdata_i(data_wdata_i), .data_gnt_o(data_gnt_o),
    .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o), .data_err_o(data_err_o),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
    .mem_rdata_i(mem_rdata_i), .mem_err_i(mem_err_i), .busy_o(busy_o),
    .protocol_err_o(protocol_err_o)
  );

  task automatic idle_inputs();
    instr_req_i = 1'b0; instr_addr_i = '0;
    data_req_i = 1'b0; data_addr_i = '0; data_we_i = 1'b0; data_be_i = '0; data_wdata_i = '0;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0; mem_err_i = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    n_cmp++;
    if ({instr_gnt_o, data_gnt_o, instr_rvalid_o, data_rvalid_o, instr_err_o, data_err_o,
         mem_req_o, busy_o, protocol_err_o} !== 9'b0) begin
      n_err++;
      $display("FAIL reset_outputs: got %b required 0", {instr_gnt_o, data_gnt_o, instr_rvalid_o,
               data_rvalid_o, instr_err_o, data_err_o, mem_req_o, busy_o, protocol_err_o});
    end
  endtask

  task automatic test_single_fetch();
    apply_reset();
    instr_req_i = 1'b1; instr_addr_i = 32'h100; mem_gnt_i = 1'b1;
    #1;
    n_cmp++;
    if ({mem_req_o, instr_gnt_o, data_gnt_o, mem_we_o, mem_be_o} !== 8'b1100_1111 || mem_addr_o !== 32'h100) begin
      n_err++;
      $display("FAIL fetch_grant: req/ig/dg/we/be=%b addr=%h required 11001111 addr=100",
               {mem_req_o, instr_gnt_o, data_gnt_o, mem_we_o, mem_be_o}, mem_addr_o);
    end
    @(negedge clk); idle_inputs();
    @(negedge clk);
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'hDEADBEEF;
    #1;
    n_cmp++;
    if (instr_rvalid_o !== 1'b1 || instr_rdata_o !== 32'hDEADBEEF || data_rvalid_o !== 1'b0 || data_rdata_o !== 32'h0) begin
      n_err++;
      $display("FAIL fetch_resp: irv=%b irdata=%h drv=%b drdata=%h required 1 deadbeef 0 0",
               instr_rvalid_o, instr_rdata_o, data_rvalid_o, data_rdata_o);
    end
    @(negedge clk); idle_inputs();
    #1;
    n_cmp++;
    if (busy_o !== 1'b0) begin
      n_err++;
      $display("FAIL fetch_idle_busy: got %b required 0", busy_o);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_g [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
    logic [1:0] exp_r [4] = '{2'b00, 2'b00, 2'b01, 2'b10};
    apply_reset();
    for (int c = 0; c < 4; c++) begin
      instr_req_i = 1'b1; instr_addr_i = 32'h40 + 32'(c);
      data_req_i = 1'b1; data_addr_i = 32'h80 + 32'(c);
      mem_gnt_i = 1'b1; mem_rvalid_i = (c >= 2);
      #1;
      n_cmp++;
      if ({instr_gnt_o, data_gnt_o} !== exp_g[c] || {instr_rvalid_o, data_rvalid_o} !== exp_r[c]) begin
        n_err++;
        $display("FAIL rr_cycle%0d: gnt(i,d)=%b rv(i,d)=%b required %b %b", c,
                 {instr_gnt_o, data_gnt_o}, {instr_rvalid_o, data_rvalid_o}, exp_g[c], exp_r[c]);
      end
      @(negedge clk);
    end
    idle_inputs();
    mem_rvalid_i = 1'b1;
    #1;
    n_cmp++;
    if ({instr_rvalid_o, data_rvalid_o} !== 2'b01) begin
      n_err++;
      $display("FAIL rr_drain0: rv(i,d)=%b required 01", {instr_rvalid_o, data_rvalid_o});
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if ({instr_rvalid_o, data_rvalid_o} !== 2'b10) begin
      n_err++;
      $display("FAIL rr_drain1: rv(i,d)=%b required 10", {instr_rvalid_o, data_rvalid_o});
    end
    @(negedge clk); idle_inputs();
  endtask

  task automatic test_hold();
    apply_reset();
    data_req_i = 1'b1; data_addr_i = 32'h200; data_we_i = 1'b1; data_be_i = 4'h3; data_wdata_i = 32'hCAFE;
    for (int c = 0; c < 4; c++) begin
      mem_gnt_i = (c == 3);
      if (c >= 1) begin instr_req_i = 1'b1; instr_addr_i = 32'h300; end
      #1;
      n_cmp++;
      if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h200 || mem_be_o !== 4'h3 || mem_we_o !== 1'b1 ||
          mem_wdata_o !== 32'hCAFE || instr_gnt_o !== 1'b0 || data_gnt_o !== (c == 3)) begin
        n_err++;
        $display("FAIL hold_cycle%0d: req=%b addr=%h be=%h we=%b ig=%b dg=%b required 1 200 3 1 0 %0d",
                 c, mem_req_o, mem_addr_o, mem_be_o, mem_we_o, instr_gnt_o, data_gnt_o, c == 3);
      end
      @(negedge clk);
    end
    data_req_i = 1'b0; mem_gnt_i = 1'b1;
    #1;
    n_cmp++;
    if (instr_gnt_o !== 1'b1 || mem_addr_o !== 32'h300 || mem_we_o !== 1'b0) begin
      n_err++;
      $display("FAIL hold_then_instr: ig=%b addr=%h we=%b required 1 300 0", instr_gnt_o, mem_addr_o, mem_we_o);
    end
    @(negedge clk); idle_inputs();
  endtask

  task automatic test_flow_control();
    apply_reset();
    instr_req_i = 1'b1; mem_gnt_i = 1'b1;
    @(negedge clk);
    instr_req_i = 1'b0; data_req_i = 1'b1;
    @(negedge clk);
    data_req_i = 1'b0; instr_req_i = 1'b1; instr_addr_i = 32'h44;
    #1;
    n_cmp++;
    if (mem_req_o !== 1'b0 || instr_gnt_o !== 1'b0 || busy_o !== 1'b1) begin
      n_err++;
      $display("FAIL full_block: req=%b ig=%b busy=%b required 0 0 1", mem_req_o, instr_gnt_o, busy_o);
    end
    @(negedge clk);
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h55;
    #1;
    n_cmp++;
    if (instr_rvalid_o !== 1'b1 || instr_rdata_o !== 32'h55 || data_rvalid_o !== 1'b0 ||
        mem_req_o !== 1'b1 || instr_gnt_o !== 1'b1) begin
      n_err++;
      $display("FAIL full_pushpop: irv=%b irdata=%h drv=%b req=%b ig=%b required 1 55 0 1 1",
               instr_rvalid_o, instr_rdata_o, data_rvalid_o, mem_req_o, instr_gnt_o);
    end
    @(negedge clk);
    idle_inputs(); data_req_i = 1'b1; mem_gnt_i = 1'b1;
    #1;
    n_cmp++;
    if (mem_req_o !== 1'b0 || data_gnt_o !== 1'b0) begin
      n_err++;
      $display("FAIL full_count_kept: req=%b dg=%b required 0 0", mem_req_o, data_gnt_o);
    end
    @(negedge clk);
    idle_inputs(); mem_rvalid_i = 1'b1;
    #1;
    n_cmp++;
    if ({instr_rvalid_o, data_rvalid_o} !== 2'b01) begin
      n_err++;
      $display("FAIL full_drain0: rv(i,d)=%b required 01", {instr_rvalid_o, data_rvalid_o});
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if ({instr_rvalid_o, data_rvalid_o} !== 2'b10) begin
      n_err++;
      $display("FAIL full_drain1: rv(i,d)=%b required 10", {instr_rvalid_o, data_rvalid_o});
    end
    @(negedge clk); idle_inputs();
  endtask

  task automatic test_error_routing();
    apply_reset();
    instr_req_i = 1'b1; mem_gnt_i = 1'b1;
    @(negedge clk);
    instr_req_i = 1'b0; data_req_i = 1'b1;
    @(negedge clk);
    idle_inputs(); mem_rvalid_i = 1'b1; mem_rdata_i = 32'h11;
    #1;
    n_cmp++;
    if (instr_rvalid_o !== 1'b1 || instr_rdata_o !== 32'h11 || instr_err_o !== 1'b0 ||
        data_rvalid_o !== 1'b0 || data_rdata_o !== 32'h0) begin
      n_err++;
      $display("FAIL route_instr: irv=%b irdata=%h ierr=%b drv=%b drdata=%h required 1 11 0 0 0",
               instr_rvalid_o, instr_rdata_o, instr_err_o, data_rvalid_o, data_rdata_o);
    end
    @(negedge clk);
    mem_rdata_i = 32'h22; mem_err_i = 1'b1;
    #1;
    n_cmp++;
    if (data_rvalid_o !== 1'b1 || data_rdata_o !== 32'h22 || data_err_o !== 1'b1 ||
        instr_rvalid_o !== 1'b0 || instr_err_o !== 1'b0 || instr_rdata_o !== 32'h0) begin
      n_err++;
      $display("FAIL route_data_err: drv=%b drdata=%h derr=%b irv=%b ierr=%b irdata=%h required 1 22 1 0 0 0",
               data_rvalid_o, data_rdata_o, data_err_o, instr_rvalid_o, instr_err_o, instr_rdata_o);
    end
    @(negedge clk); idle_inputs();
  endtask

  task automatic test_reset_in_hold();
    apply_reset();
    instr_req_i = 1'b1; mem_gnt_i = 1'b1;
    @(negedge clk);
    instr_req_i = 1'b0; data_req_i = 1'b1; mem_gnt_i = 1'b0;
    @(negedge clk);
    rst = 1'b1; mem_rvalid_i = 1'b1;
    #1;
    n_cmp++;
    if ({mem_req_o, data_gnt_o, instr_gnt_o, instr_rvalid_o, data_rvalid_o, busy_o, protocol_err_o} !== 7'b0) begin
      n_err++;
      $display("FAIL rst_in_hold: req/dg/ig/irv/drv/busy/perr=%b required 0", {mem_req_o, data_gnt_o,
               instr_gnt_o, instr_rvalid_o, data_rvalid_o, busy_o, protocol_err_o});
    end
    @(negedge clk); @(negedge clk);
    rst = 1'b0; data_req_i = 1'b0;
    #1;
    n_cmp++;
    if (instr_rvalid_o !== 1'b0 || data_rvalid_o !== 1'b0) begin
      n_err++;
      $display("FAIL rst_stray_rvalid: irv=%b drv=%b required 0 0", instr_rvalid_o, data_rvalid_o);
    end
    @(negedge clk); idle_inputs();
    #1;
    n_cmp++;
    if (protocol_err_o !== 1'b1 || busy_o !== 1'b0) begin
      n_err++;
      $display("FAIL rst_protocol_err: perr=%b busy=%b required 1 0", protocol_err_o, busy_o);
    end
  endtask

  task automatic test_random();
    int q[$];
    int last = 0, hold = -1, ch;
    bit ip = 0, dp = 0, rv, exp_req, eg_i, eg_d, erv_i, erv_d;
    logic [31:0] ia = '0, da = '0, dw = '0, rd;
    logic [3:0]  dbe = '0;
    logic        dwe = 1'b0, er;
    logic [31:0] exp_addr, exp_wd;
    logic [3:0]  exp_be;
    logic        exp_we;
    apply_reset();
    for (int c = 0; c < 400; c++) begin
      if (c != 0) @(negedge clk);
      if (!ip && $urandom_range(2) == 0) begin ip = 1; ia = $urandom; end
      if (!dp && $urandom_range(2) == 0) begin
        dp = 1; da = $urandom; dw = $urandom; dbe = 4'($urandom); dwe = 1'($urandom);
      end
      instr_req_i = ip; instr_addr_i = ia;
      data_req_i = dp; data_addr_i = da; data_we_i = dwe; data_be_i = dbe; data_wdata_i = dw;
      mem_gnt_i = 1'($urandom);
      rv = (q.size() > 0) && ($urandom_range(1) == 1);
      rd = $urandom; er = 1'($urandom);
      mem_rvalid_i = rv; mem_rdata_i = rd; mem_err_i = er;
      #1;
      ch = -1;
      if (hold >= 0) ch = hold;
      else if ((ip || dp) && (q.size() < MAX_OUT || rv))
        ch = (ip && dp) ? ((PRIO == 1) ? 1 : (last == 0 ? 1 : 0)) : (dp ? 1 : 0);
      exp_req = (ch >= 0);
      eg_i = exp_req && mem_gnt_i && ch == 0;
      eg_d = exp_req && mem_gnt_i && ch == 1;
      erv_i = rv && q[0] == 0;
      erv_d = rv && q[0] == 1;
      n_cmp++;
      if ({mem_req_o, instr_gnt_o, data_gnt_o, busy_o} !== {exp_req, eg_i, eg_d, exp_req || q.size() != 0}) begin
        n_err++;
        $display("FAIL rnd_arb c%0d: req/ig/dg/busy=%b required %b", c,
                 {mem_req_o, instr_gnt_o, data_gnt_o, busy_o}, {exp_req, eg_i, eg_d, exp_req || q.size() != 0});
      end
      if (exp_req) begin
        exp_addr = (ch == 1) ? da : ia;
        exp_we   = (ch == 1) ? dwe : 1'b0;
        exp_be   = (ch == 1) ? dbe : 4'hF;
        exp_wd   = (ch == 1) ? dw : 32'h0;
        n_cmp++;
        if (mem_addr_o !== exp_addr || mem_we_o !== exp_we || mem_be_o !== exp_be || mem_wdata_o !== exp_wd) begin
          n_err++;
          $display("FAIL rnd_payload c%0d: addr=%h we=%b be=%h wd=%h required %h %b %h %h", c,
                   mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o, exp_addr, exp_we, exp_be, exp_wd);
        end
      end
      n_cmp++;
      if (instr_rvalid_o !== erv_i || data_rvalid_o !== erv_d ||
          instr_rdata_o !== (erv_i ? rd : 32'h0) || data_rdata_o !== (erv_d ? rd : 32'h0) ||
          instr_err_o !== (erv_i && er) || data_err_o !== (erv_d && er) || protocol_err_o !== 1'b0) begin
        n_err++;
        $display("FAIL rnd_resp c%0d: irv=%b drv=%b ird=%h drd=%h ierr=%b derr=%b perr=%b required %b %b data %h err %b perr 0",
                 c, instr_rvalid_o, data_rvalid_o, instr_rdata_o, data_rdata_o, instr_err_o, data_err_o,
                 protocol_err_o, erv_i, erv_d, rd, er);
      end
      if (rv) void'(q.pop_front());
      if (eg_i || eg_d) begin q.push_back(ch); last = ch; end
      hold = (exp_req && !mem_gnt_i) ? ch : -1;
      if (eg_i) ip = 0;
      if (eg_d) dp = 0;
    end
    @(negedge clk); idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single_fetch();
    test_round_robin();
    test_hold();
    test_flow_control();
    test_error_routing();
    test_reset_in_hold();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one unified memory port between the core's instruction-fetch and data (load/store) request channels. Both channels use a req/gnt/rvalid handshake. The block arbitrates requests, holds the chosen request stable until the memory grants it, and tracks outstanding transactions in order. It routes each response (rdata/err) back to the channel that issued it. It sits between the core top level and the single-ported memory model/controller.

Parameters:
MAX_OUT, 2, maximum outstanding (granted, not yet responded) transactions; 1..8
PRIO_MODE, 0, 0 = round-robin on ties; 1 = data channel has fixed priority
AW, 32, address width
DW, 32, data width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
instr_req_i  in  1  fetch request
instr_addr_i  in  AW  fetch address
instr_gnt_o  out  1  fetch accepted this cycle
instr_rvalid_o  out  1  fetch response valid
instr_rdata_o  out  DW  fetch data
instr_err_o  out  1  fetch bus error
data_req_i  in  1  load/store request
data_addr_i  in  AW  data address
data_we_i  in  1  1 = store
data_be_i  in  4  byte enables
data_wdata_i  in  DW  store data
data_gnt_o  out  1  data accepted this cycle
data_rvalid_o  out  1  data response valid
data_rdata_o  out  DW  load data
data_err_o  out  1  data bus error
mem_req_o  out  1  memory request
mem_addr_o  out  AW  memory address
mem_we_o  out  1  memory write enable
mem_be_o  out  4  memory byte enables
mem_wdata_o  out  DW  memory write data
mem_gnt_i  in  1  memory accepts the request
mem_rvalid_i  in  1  memory response valid
mem_rdata_i  in  DW  memory read data
mem_err_i  in  1  memory error
busy_o  out  1  any request pending or outstanding
protocol_err_o  out  1  sticky: rvalid received with no outstanding transaction

Behaviour:
- One clock, clk. rst is asynchronous, active-high.
- Reset values: all *_gnt_o, *_rvalid_o, *_err_o, mem_req_o, busy_o and protocol_err_o are 0. Outstanding count is 0, ID FIFO is empty, FSM is in ARB, and last_winner is INSTR.
- FSM states:
  - ARB: selection is free.
  - HOLD: mem_req_o was asserted and not yet granted; the selected channel is latched.
- ARB transitions:
  - If a request exists, outstanding < MAX_OUT and mem_gnt_i=0: drive mem_req_o and go to HOLD.
  - If mem_gnt_i=1 in the same cycle: grant and stay in ARB.
- HOLD transitions:
  - mem_req_o and all mem_* payload come from the latched channel and stay stable. Requests from the other channel are ignored.
  - On mem_gnt_i=1: go to ARB.
- Selection in ARB:
  - Only one channel requesting: that channel wins.
  - Both requesting, PRIO_MODE=1: data wins.
  - Both requesting, PRIO_MODE=0: the channel that is not last_winner wins. The first tie after reset goes to data.
  - last_winner updates only on a grant.
- Payload for instruction requests: mem_we_o=0, mem_be_o=4'hF, mem_wdata_o=0. Data requests pass through unchanged.
- Grant:
  - Upstream gnt = mem_gnt_i AND mem_req_o AND (selected channel); combinational, zero latency.
  - On a grant, the winner's 1-bit ID is pushed to the in-order ID FIFO (depth MAX_OUT).
- Flow control: when outstanding == MAX_OUT, mem_req_o=0 and both gnts are 0. HOLD cannot be entered in this condition.
- Response:
  - On mem_rvalid_i, pop the FIFO head.
  - Assert rvalid_o, rdata_o and err_o combinationally on the matching channel only.
  - The other channel's rdata_o is 0.
- Simultaneous grant and rvalid in one cycle: push and pop together. Count is unchanged. Response routing uses the pre-push head. A full FIFO still accepts the grant in that cycle, because the pop frees the slot.
- mem_rvalid_i with an empty FIFO: the response is dropped, no upstream rvalid is raised, and protocol_err_o is set. It clears only on rst.
- Reset mid-operation: HOLD is abandoned and all outstanding IDs are discarded. Responses arriving after reset is released are treated as protocol errors.
- busy_o = mem_req_o OR (outstanding != 0).

Decomposition:
- Package mem_arb_pkg holds:
  - typedef enum requester ID {REQ_INSTR, REQ_DATA}
  - typedef enum FSM state {ARB, HOLD}
  - localparam INSTR_BE = 4'hF
- One sub-module, mem_arb_id_fifo: a synchronous FIFO of 1-bit IDs, depth MAX_OUT, with push/pop/full/empty/count and simultaneous push+pop when full.

Test Plan:
- Single fetch at 0x100, mem_gnt_i=1 immediately, rvalid 2 cycles later with rdata 0xDEADBEEF -> instr_gnt_o pulses in cycle 0; instr_rvalid_o with 0xDEADBEEF; mem_be_o=4'hF, mem_we_o=0.
- Both channels request every cycle, PRIO_MODE=0, mem_gnt_i=1 constantly -> grant order is data, instr, data, instr.
- Data store to 0x200, be=4'h3, mem_gnt_i held 0 for 3 cycles while an instr request arrives -> mem_addr_o stays 0x200 all 3 cycles; instr is granted only after the data grant.
- MAX_OUT=2, two grants with no rvalid -> third request sees mem_req_o=0. Then rvalid and grant in the same cycle -> response routed to the first ID and the new request is granted; count stays 2.
- Interleaved instr then data grants, responses 0x11 then 0x22 with mem_err_i=1 on the second -> instr_rdata_o=0x11; data_rdata_o=0x22 with data_err_o=1.
- Assert rst while in HOLD with 1 outstanding, release, then mem_rvalid_i=1 -> all outputs 0 during reset; protocol_err_o=1 afterwards; no upstream rvalid.
